// File: rtl/icache_direct.sv
// Direct-mapped, one-word-per-line instruction cache; ICACHE_STATS_EN adds hit/miss counters.
// Latency: hit is combinational; a miss stalls 1 cycle plus every memory wait cycle up to and including the ack.
// Backpressure: stall_o holds the core while memory is slow; mem_req_o stays high until mem_ack_i.
module icache_direct #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int IDX_W  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rom_ce_i,
  input  logic [ADDR_W-1:0] rom_addr_i,
  output logic [DATA_W-1:0] rom_data_o,
  output logic              stall_o,
  input  logic              flush_i,
  output logic              mem_req_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  input  logic [DATA_W-1:0] mem_rdata_i,
  input  logic              mem_ack_i
`ifdef ICACHE_STATS_EN
  ,
  output logic [31:0]       hit_cnt_o,
  output logic [31:0]       miss_cnt_o
`endif
);

  localparam int LINES = 1 << IDX_W;
  localparam int TAG_W = ADDR_W - IDX_W - 2;

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] WAIT = 1'b1;

  logic [0:0]        state;
  logic [LINES-1:0]  valid;
  logic [TAG_W-1:0]  tag_mem  [LINES];
  logic [DATA_W-1:0] data_mem [LINES];
  logic [TAG_W-1:0]  miss_tag;
  logic [IDX_W-1:0]  miss_idx;
  logic              discard;

  logic [IDX_W-1:0]  idx;
  logic [TAG_W-1:0]  tag;
  logic              hit;
  logic              lookup;
  logic              fill;
  logic              unused_byte_off;

  assign idx             = rom_addr_i[IDX_W+1:2];
  assign tag             = rom_addr_i[ADDR_W-1:IDX_W+2];
  assign unused_byte_off = ^rom_addr_i[1:0];

  assign hit    = valid[idx] && (tag_mem[idx] == tag);
  assign lookup = (state == IDLE) && rom_ce_i;
  assign fill   = (state == WAIT) && mem_ack_i;

  always_comb begin
    rom_data_o = '0;
    stall_o    = 1'b0;
    mem_req_o  = 1'b0;
    mem_addr_o = '0;
    if (state == WAIT) begin
      stall_o    = 1'b1;
      mem_req_o  = 1'b1;
      mem_addr_o = {miss_tag, miss_idx, 2'b00};
    end else if (lookup) begin
      if (hit) begin
        rom_data_o = data_mem[idx];
      end else begin
        stall_o = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      valid    <= '0;
      discard  <= 1'b0;
      miss_tag <= '0;
      miss_idx <= '0;
    end else begin
      if (state == IDLE) begin
        if (lookup && !hit) begin
          miss_tag <= tag;
          miss_idx <= idx;
          state    <= WAIT;
        end
      end else if (mem_ack_i) begin
        state <= IDLE;
      end

      // A flush always wins, including over a fill landing in the same cycle.
      if (flush_i) begin
        valid <= '0;
      end else if (fill && !discard) begin
        valid[miss_idx] <= 1'b1;
      end

      // Fill already in flight when a flush arrives must not become visible.
      if (fill) begin
        discard <= 1'b0;
      end else if (flush_i && (state == WAIT)) begin
        discard <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && fill) begin
      data_mem[miss_idx] <= mem_rdata_i;
      tag_mem[miss_idx]  <= miss_tag;
    end
  end

`ifdef ICACHE_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      hit_cnt_o  <= '0;
      miss_cnt_o <= '0;
    end else begin
      if (lookup && hit) begin
        hit_cnt_o <= hit_cnt_o + 32'd1;
      end
      if (lookup && !hit) begin
        miss_cnt_o <= miss_cnt_o + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_icache_direct.sv
// Directed bench for icache_direct: per-cycle vector table plus hand sequences for flush and reset corners.
module tb_icache_direct;

  logic        clk = 1'b0;
  logic        rst;
  logic        rom_ce_i;
  logic [31:0] rom_addr_i;
  logic [31:0] rom_data_o;
  logic        stall_o;
  logic        flush_i;
  logic        mem_req_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_rdata_i;
  logic        mem_ack_i;
`ifdef ICACHE_STATS_EN
  logic [31:0] hit_cnt_o;
  logic [31:0] miss_cnt_o;
`endif

  icache_direct #(.ADDR_W(32), .DATA_W(32), .IDX_W(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .rom_ce_i    (rom_ce_i),
    .rom_addr_i  (rom_addr_i),
    .rom_data_o  (rom_data_o),
    .stall_o     (stall_o),
    .flush_i     (flush_i),
    .mem_req_o   (mem_req_o),
    .mem_addr_o  (mem_addr_o),
    .mem_rdata_i (mem_rdata_i),
    .mem_ack_i   (mem_ack_i)
`ifdef ICACHE_STATS_EN
    ,
    .hit_cnt_o   (hit_cnt_o),
    .miss_cnt_o  (miss_cnt_o)
`endif
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic        ce;
    logic [31:0] addr;
    logic        flush;
    logic        ack;
    logic [31:0] rdata;
    logic [31:0] exp_d;
    logic        exp_s;
    logic        exp_r;
    logic [31:0] exp_a;
    int          exp_h;
    int          exp_m;
  } vec_t;

  vec_t tbl[19];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Inputs change at the falling edge; outputs are sampled 1ns later, well before the rising edge.
  task automatic drive(input logic ce, input logic [31:0] addr, input logic flush,
                       input logic ack, input logic [31:0] rdata);
    @(negedge clk);
    rst         = 1'b0;
    rom_ce_i    = ce;
    rom_addr_i  = addr;
    flush_i     = flush;
    mem_ack_i   = ack;
    mem_rdata_i = rdata;
    #1;
  endtask

  task automatic step(input string nm, input logic ce, input logic [31:0] addr, input logic flush,
                      input logic ack, input logic [31:0] rdata, input logic [31:0] exp_d,
                      input logic exp_s, input logic exp_r, input logic [31:0] exp_a);
    drive(ce, addr, flush, ack, rdata);
    chk({nm, ".data"},  rom_data_o, exp_d);
    chk({nm, ".stall"}, {31'd0, stall_o}, {31'd0, exp_s});
    chk({nm, ".req"},   {31'd0, mem_req_o}, {31'd0, exp_r});
    chk({nm, ".maddr"}, mem_addr_o, exp_a);
  endtask

  initial begin
    rst         = 1'b1;
    rom_ce_i    = 1'b0;
    rom_addr_i  = '0;
    flush_i     = 1'b0;
    mem_ack_i   = 1'b0;
    mem_rdata_i = '0;

    //            ce  addr          fl  ack rdata         exp_d         s  r  exp_a         h  m
    tbl[0]  = '{1'b0, 32'h00000000, 1'b0, 1'b0, 32'h0,        32'h0,        1'b0, 1'b0, 32'h0,  0, 0};
    tbl[1]  = '{1'b1, 32'h00000000, 1'b0, 1'b0, 32'h0,        32'h0,        1'b1, 1'b0, 32'h0,  0, 0};
    tbl[2]  = '{1'b1, 32'h00000000, 1'b0, 1'b0, 32'h0,        32'h0,        1'b1, 1'b1, 32'h0,  0, 1};
    tbl[3]  = '{1'b1, 32'h00000000, 1'b0, 1'b0, 32'h0,        32'h0,        1'b1, 1'b1, 32'h0,  0, 1};
    tbl[4]  = '{1'b1, 32'h00000000, 1'b0, 1'b1, 32'h00000013, 32'h0,        1'b1, 1'b1, 32'h0,  0, 1};
    tbl[5]  = '{1'b1, 32'h00000000, 1'b0, 1'b0, 32'h0,        32'h00000013, 1'b0, 1'b0, 32'h0,  0, 1};
    tbl[6]  = '{1'b1, 32'h00000000, 1'b0, 1'b0, 32'h0,        32'h00000013, 1'b0, 1'b0, 32'h0,  1, 1};
    tbl[7]  = '{1'b1, 32'h00000040, 1'b0, 1'b0, 32'h0,        32'h0,        1'b1, 1'b0, 32'h0,  2, 1};
    tbl[8]  = '{1'b1, 32'h00000040, 1'b0, 1'b1, 32'hDEADBEEF, 32'h0,        1'b1, 1'b1, 32'h40, 2, 2};
    tbl[9]  = '{1'b1, 32'h00000040, 1'b0, 1'b0, 32'h0,        32'hDEADBEEF, 1'b0, 1'b0, 32'h0,  2, 2};
    tbl[10] = '{1'b1, 32'h00000000, 1'b0, 1'b0, 32'h0,        32'h0,        1'b1, 1'b0, 32'h0,  3, 2};
    tbl[11] = '{1'b1, 32'h00000000, 1'b0, 1'b0, 32'h0,        32'h0,        1'b1, 1'b1, 32'h0,  3, 3};
    tbl[12] = '{1'b1, 32'h00000000, 1'b0, 1'b1, 32'h00000013, 32'h0,        1'b1, 1'b1, 32'h0,  3, 3};
    tbl[13] = '{1'b1, 32'h00000000, 1'b0, 1'b0, 32'h0,        32'h00000013, 1'b0, 1'b0, 32'h0,  3, 3};
    tbl[14] = '{1'b0, 32'h00000000, 1'b0, 1'b1, 32'h00000BAD, 32'h0,        1'b0, 1'b0, 32'h0,  4, 3};
    tbl[15] = '{1'b1, 32'h00000000, 1'b0, 1'b0, 32'h0,        32'h00000013, 1'b0, 1'b0, 32'h0,  4, 3};
    tbl[16] = '{1'b1, 32'h00000000, 1'b0, 1'b1, 32'h00000BAD, 32'h00000013, 1'b0, 1'b0, 32'h0,  5, 3};
    tbl[17] = '{1'b1, 32'h00000000, 1'b0, 1'b0, 32'h0,        32'h00000013, 1'b0, 1'b0, 32'h0,  6, 3};
    tbl[18] = '{1'b1, 32'h00000003, 1'b0, 1'b0, 32'h0,        32'h00000013, 1'b0, 1'b0, 32'h0,  7, 3};

    repeat (2) @(negedge clk);

    for (int i = 0; i < 19; i++) begin
      step($sformatf("vec%0d", i), tbl[i].ce, tbl[i].addr, tbl[i].flush, tbl[i].ack, tbl[i].rdata,
           tbl[i].exp_d, tbl[i].exp_s, tbl[i].exp_r, tbl[i].exp_a);
`ifdef ICACHE_STATS_EN
      chk($sformatf("vec%0d.hit_cnt", i),  hit_cnt_o,  tbl[i].exp_h);
      chk($sformatf("vec%0d.miss_cnt", i), miss_cnt_o, tbl[i].exp_m);
`endif
    end

    // Flush in the first WAIT cycle: the fill lands but stays invalid, line 0 is lost too.
    step("fw_miss",   1'b1, 32'h8, 1'b0, 1'b0, 32'h0,  32'h0,  1'b1, 1'b0, 32'h0);
    step("fw_wait1",  1'b1, 32'h8, 1'b1, 1'b0, 32'h0,  32'h0,  1'b1, 1'b1, 32'h8);
    step("fw_ack",    1'b1, 32'h8, 1'b0, 1'b1, 32'h11, 32'h0,  1'b1, 1'b1, 32'h8);
    step("fw_remiss", 1'b1, 32'h8, 1'b0, 1'b0, 32'h0,  32'h0,  1'b1, 1'b0, 32'h0);
    step("fw_refill", 1'b1, 32'h8, 1'b0, 1'b1, 32'h11, 32'h0,  1'b1, 1'b1, 32'h8);
    step("fw_hit",    1'b1, 32'h8, 1'b0, 1'b0, 32'h0,  32'h11, 1'b0, 1'b0, 32'h0);
    step("fw_l0miss", 1'b1, 32'h0, 1'b0, 1'b0, 32'h0,  32'h0,  1'b1, 1'b0, 32'h0);
    step("fw_l0fill", 1'b1, 32'h0, 1'b0, 1'b1, 32'h13, 32'h0,  1'b1, 1'b1, 32'h0);
    step("fw_l0hit",  1'b1, 32'h0, 1'b0, 1'b0, 32'h0,  32'h13, 1'b0, 1'b0, 32'h0);

    // Flush coincident with the ack: the line must stay invalid.
    step("fa_miss",     1'b1, 32'h10, 1'b0, 1'b0, 32'h0,  32'h0,  1'b1, 1'b0, 32'h0);
    step("fa_ackflush", 1'b1, 32'h10, 1'b1, 1'b1, 32'h22, 32'h0,  1'b1, 1'b1, 32'h10);
    step("fa_remiss",   1'b1, 32'h10, 1'b0, 1'b0, 32'h0,  32'h0,  1'b1, 1'b0, 32'h0);
    step("fa_fill",     1'b1, 32'h10, 1'b0, 1'b1, 32'h22, 32'h0,  1'b1, 1'b1, 32'h10);
    step("fa_hit",      1'b1, 32'h10, 1'b0, 1'b0, 32'h0,  32'h22, 1'b0, 1'b0, 32'h0);

    // Flush in IDLE: same-cycle lookup still hits, the next one misses.
    step("fi_hit",  1'b1, 32'h10, 1'b1, 1'b0, 32'h0,  32'h22, 1'b0, 1'b0, 32'h0);
    step("fi_miss", 1'b1, 32'h10, 1'b0, 1'b0, 32'h0,  32'h0,  1'b1, 1'b0, 32'h0);
    step("fi_fill", 1'b1, 32'h10, 1'b0, 1'b1, 32'h22, 32'h0,  1'b1, 1'b1, 32'h10);
    step("fi_hit2", 1'b1, 32'h10, 1'b0, 1'b0, 32'h0,  32'h22, 1'b0, 1'b0, 32'h0);

    // Upper tag bit differs on the same index: conflict miss and refill.
    step("tag_miss", 1'b1, 32'h80000010, 1'b0, 1'b0, 32'h0,  32'h0,  1'b1, 1'b0, 32'h0);
    step("tag_fill", 1'b1, 32'h80000010, 1'b0, 1'b1, 32'h33, 32'h0,  1'b1, 1'b1, 32'h80000010);
    step("tag_hit",  1'b1, 32'h80000010, 1'b0, 1'b0, 32'h0,  32'h33, 1'b0, 1'b0, 32'h0);
    step("tag_old",  1'b1, 32'h00000010, 1'b0, 1'b0, 32'h0,  32'h0,  1'b1, 1'b0, 32'h0);
    step("tag_ofil", 1'b1, 32'h00000010, 1'b0, 1'b1, 32'h22, 32'h0,  1'b1, 1'b1, 32'h10);

    // Reset mid-miss: the request is dropped and a late ack is ignored.
    step("rm_miss", 1'b1, 32'h20, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h0);
    step("rm_wait", 1'b1, 32'h20, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 32'h20);
    @(negedge clk);
    rst       = 1'b1;
    rom_ce_i  = 1'b0;
    mem_ack_i = 1'b0;
    flush_i   = 1'b0;
    step("rm_stray",  1'b0, 32'h20, 1'b0, 1'b1, 32'h99, 32'h0, 1'b0, 1'b0, 32'h0);
`ifdef ICACHE_STATS_EN
    chk("rm_stray.hit_cnt",  hit_cnt_o,  32'd0);
    chk("rm_stray.miss_cnt", miss_cnt_o, 32'd0);
`endif
    step("rm_remiss", 1'b1, 32'h20, 1'b0, 1'b0, 32'h0,  32'h0, 1'b1, 1'b0, 32'h0);
    step("rm_l0miss", 1'b1, 32'h20, 1'b0, 1'b1, 32'h44, 32'h0, 1'b1, 1'b1, 32'h20);
    step("rm_hit",    1'b1, 32'h20, 1'b0, 1'b0, 32'h0,  32'h44, 1'b0, 1'b0, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
